debug_trace_monitor: RTL

On-chip consumer of the CPU core's debug interface. It samples the committed PC (`debug_pc_out`) and the `reg3` tap every cycle and detects end-of-test (PC reaches a fixed address) and hang (PC frozen). It grades the result against an expected `reg3` value, drives the board LED and buffers a PC-change trace in a small FIFO for readout. It sits beside `my_cpu` at the top level and replaces the simulation-only PC check with synthesizable pass/fail logic.

---
 rtl/debug_trace_monitor.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/debug_trace_monitor.sv
// -----------------------------------------------------------------------------
// debug_trace_monitor
//
// Watches the CPU core's debug interface and decides how the test ended.
// Every clock it samples the committed PC and the reg3 tap. The test ends in
// one of two ways:
//   - the PC reaches DONE_PC. The result is PASS if reg3 equals PASS_VALUE and
//     FAIL otherwise.
//   - the PC stops changing for STALL_LIMIT consecutive samples. The result is
//     FAIL with hang set.
// PASS and FAIL hold until reset. The LED is off while the test runs, steady
// on for PASS, and blinks for FAIL with a half-period of BLINK_DIV clocks.
// While the test runs, every PC change is written to a small trace FIFO that
// can be read out through the trace_* port.
//
// Build option:
//   TRACE_FIFO_EN  defined   -> the trace FIFO and its read port are built.
//                  undefined -> no FIFO storage is built. trace_empty=1,
//                               trace_valid=0, trace_data=0 and trace_ovf=0
//                               are constant, and trace_rd_en is ignored.
//
// Ports:
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   debug_pc_in  in  32   committed PC from the core
//   reg3_in      in  32   core reg3 tap
//   done         out  1   sticky, test finished
//   pass         out  1   sticky, finished with reg3 == PASS_VALUE
//   fail         out  1   sticky, finished with wrong reg3 or a hang
//   hang         out  1   sticky, the failure was a PC stall
//   led          out  1   status LED
//   trace_rd_en  in   1   pop request
//   trace_data   out 32   popped PC, valid the cycle after an accepted pop
//   trace_valid  out  1   trace_data is valid this cycle
//   trace_empty  out  1   trace FIFO is empty
//   trace_ovf    out  1   sticky, a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module debug_trace_monitor #(
   parameter logic [31:0] DONE_PC     = 32'h0000_0044,
   parameter logic [31:0] PASS_VALUE  = 32'h0000_0001,
   parameter int unsigned STALL_LIMIT = 32'd1024,
   parameter int unsigned DEPTH       = 32'd16,
   parameter int unsigned BLINK_DIV   = 32'd25_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] debug_pc_in,
   input  logic [31:0] reg3_in,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        hang,
   output logic        led,
   input  logic        trace_rd_en,
   output logic [31:0] trace_data,
   output logic        trace_valid,
   output logic        trace_empty,
   output logic        trace_ovf
);

   localparam int unsigned SW = $clog2(STALL_LIMIT);
   localparam int unsigned BW = (BLINK_DIV > 32'd1) ? $clog2(BLINK_DIV) : 32'd1;
   localparam logic [SW-1:0] STALL_TOP = SW'(STALL_LIMIT - 32'd1);
   localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 32'd1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_nx_s;
   logic           hang_set_s;
   logic [31:0]    pc_q_r;
   logic [SW-1:0]  stall_cnt_r;
   logic [BW-1:0]  blink_cnt_r;
   logic           in_run_s;
   logic           change_s;
   logic           done_hit_s;
   logic           stall_hit_s;
   logic           done_r;
   logic           pass_r;
   logic           fail_r;
   logic           hang_r;
   logic           led_r;

   // pc_q_r starts at all ones, so the first sample after reset counts as a
   // change and is traced.
   assign in_run_s    = (state_r == ST_RUN);
   assign change_s    = (debug_pc_in != pc_q_r);
   assign done_hit_s  = (debug_pc_in == DONE_PC);
   assign stall_hit_s = (stall_cnt_r == STALL_TOP) && !change_s;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic. Reaching DONE_PC takes priority over a hang on the same edge.
   always_comb begin
      state_nx_s = state_r;
      hang_set_s = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (done_hit_s) begin
               if (reg3_in == PASS_VALUE) begin
                  state_nx_s = ST_PASS;
               end else begin
                  state_nx_s = ST_FAIL;
               end
            end else if (stall_hit_s) begin
               state_nx_s = ST_FAIL;
               hang_set_s = 1'b1;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_PASS: state_nx_s = ST_PASS;
         ST_FAIL: state_nx_s = ST_FAIL;
         default: state_nx_s = ST_RUN;
      endcase
   end

   // PC sample and stall counter; both are frozen once the test has ended
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q_r      <= 32'hFFFF_FFFF;
         stall_cnt_r <= {SW{1'b0}};
      end else if (in_run_s) begin
         pc_q_r <= debug_pc_in;
         if (change_s) begin
            stall_cnt_r <= {SW{1'b0}};
         end else if (stall_cnt_r != {SW{1'b1}}) begin
            stall_cnt_r <= stall_cnt_r + SW'(1'b1);
         end
      end
   end

   // Registered status flags, taken from the next state so they appear one cycle after the deciding sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_r <= 1'b0;
         pass_r <= 1'b0;
         fail_r <= 1'b0;
         hang_r <= 1'b0;
      end else begin
         done_r <= (state_nx_s != ST_RUN);
         pass_r <= (state_nx_s == ST_PASS);
         fail_r <= (state_nx_s == ST_FAIL);
         hang_r <= hang_r | hang_set_s;
      end
   end

   // LED driver: off while running, steady on for pass, blinks for fail starting lit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_r       <= 1'b0;
         blink_cnt_r <= {BW{1'b0}};
      end else if (state_r == ST_RUN) begin
         blink_cnt_r <= {BW{1'b0}};
         led_r       <= (state_nx_s != ST_RUN);
      end else if (state_r == ST_PASS) begin
         led_r <= 1'b1;
      end else if (blink_cnt_r == BLINK_TOP) begin
         led_r       <= ~led_r;
         blink_cnt_r <= {BW{1'b0}};
      end else begin
         blink_cnt_r <= blink_cnt_r + BW'(1'b1);
      end
   end

   assign done = done_r;
   assign pass = pass_r;
   assign fail = fail_r;
   assign hang = hang_r;
   assign led  = led_r;

`ifdef TRACE_FIFO_EN
   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0] mem_r [DEPTH];
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic [AW:0] wr_ptr_nx_s;
   logic [AW:0] rd_ptr_nx_s;
   logic        empty_s;
   logic        full_s;
   logic        push_s;
   logic        pop_s;
   logic        push_ok_s;
   logic        drop_s;
   logic [31:0] trace_data_r;
   logic        trace_valid_r;
   logic        trace_empty_r;
   logic        trace_ovf_r;

   // The pointers carry one extra wrap bit so that full and empty can be told apart.
   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign push_s    = in_run_s && change_s;
   assign pop_s     = trace_rd_en && !empty_s;
   // A pop on the same edge frees a slot, so a push into a full FIFO is kept.
   assign push_ok_s = push_s && (!full_s || pop_s);
   assign drop_s    = push_s && full_s && !pop_s;

   // Next pointer values
   always_comb begin
      wr_ptr_nx_s = wr_ptr_r;
      rd_ptr_nx_s = rd_ptr_r;
      if (push_ok_s) begin
         wr_ptr_nx_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_nx_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nx_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_nx_s = rd_ptr_r;
      end
   end

   // Trace storage. When the FIFO is full, the slot read on this edge is the
   // slot written on this edge, and the read returns the old entry.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= debug_pc_in;
      end
   end

   // FIFO pointers, read port and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r      <= {(AW+1){1'b0}};
         rd_ptr_r      <= {(AW+1){1'b0}};
         trace_data_r  <= 32'h0000_0000;
         trace_valid_r <= 1'b0;
         trace_empty_r <= 1'b1;
         trace_ovf_r   <= 1'b0;
      end else begin
         wr_ptr_r      <= wr_ptr_nx_s;
         rd_ptr_r      <= rd_ptr_nx_s;
         trace_valid_r <= pop_s;
         trace_empty_r <= (wr_ptr_nx_s == rd_ptr_nx_s);
         trace_ovf_r   <= trace_ovf_r | drop_s;
         if (pop_s) begin
            trace_data_r <= mem_r[rd_ptr_r[AW-1:0]];
         end
      end
   end

   assign trace_data  = trace_data_r;
   assign trace_valid = trace_valid_r;
   assign trace_empty = trace_empty_r;
   assign trace_ovf   = trace_ovf_r;
`else
   logic unused_rd_en_s;

   assign unused_rd_en_s = trace_rd_en;
   assign trace_data     = 32'h0000_0000;
   assign trace_valid    = 1'b0;
   assign trace_empty    = 1'b1;
   assign trace_ovf      = 1'b0;
`endif

endmodule
